// File: rtl/frame_timer_pkg.sv
// Shared types and defaults for the frame timer scheduler.
//   state_e           : scheduler FSM states
//   TICK_DIV_DEFAULT  : clk cycles per frame tick (60 Hz frames from 50 MHz)
//   FRM_W_DEFAULT     : width of each requester's frame-count field
package frame_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int TICK_DIV_DEFAULT = 833334;
  localparam int FRM_W_DEFAULT    = 4;

endpackage

// File: rtl/frame_timer_scheduler_rr_pick.sv
// Combinational round-robin picker.
//   req_i        : request vector
//   ptr_i        : index with highest priority this round
//   win_onehot_o : one-hot winner (zero when no request)
//   win_idx_o    : binary index of the winner
//   any_req_o    : at least one request bit is set
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] win_onehot_o,
  output logic [IDX_W-1:0]   win_idx_o,
  output logic               any_req_o
);

  always_comb begin
    int idx;
    win_onehot_o = '0;
    win_idx_o    = '0;
    any_req_o    = 1'b0;
    idx          = 0;
    // Scan from ptr upward, wrapping; the first set bit wins.
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr_i) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_req_o && req_i[idx]) begin
        any_req_o         = 1'b1;
        win_idx_o         = IDX_W'(idx);
        win_onehot_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_timer_scheduler.sv
// Shares one frame-tick timer among NUM_REQ animation requesters.
// A round-robin arbiter grants the timer; the granted requester gets
// frame_tick pulses every TICK_DIV clocks and a done pulse after its
// requested number of frames.
//   clk, resetn : clock, synchronous active-low reset
//   req         : per-requester level request
//   frames      : per-requester frame count, field i = [i*FRM_W +: FRM_W]
//   grant       : one-hot current owner (registered)
//   done        : one-cycle completion pulse (registered)
//   frame_tick  : one-cycle pulse per completed frame (registered)
//   busy        : high while a run is in progress
module frame_timer_scheduler
  import frame_timer_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int TICK_DIV = TICK_DIV_DEFAULT,
  parameter int CNT_W    = 20,
  parameter int FRM_W    = FRM_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*FRM_W-1:0] frames,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     frame_tick,
  output logic                     busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     win_q, win_d;
  logic [FRM_W-1:0]     target_q, target_d;
  logic [CNT_W-1:0]     dly_q, dly_d;
  logic [FRM_W-1:0]     frm_q, frm_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 tick_q, tick_d;
  logic                 busy_q, busy_d;

  logic [NUM_REQ-1:0]   pick_oh;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;
  logic [FRM_W-1:0]     pick_frames;
  logic [FRM_W-1:0]     frm_inc;
  logic [IDX_W-1:0]     ptr_next;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i        (req),
    .ptr_i        (ptr_q),
    .win_onehot_o (pick_oh),
    .win_idx_o    (pick_idx),
    .any_req_o    (pick_any)
  );

  assign pick_frames = frames[pick_idx*FRM_W +: FRM_W];
  assign frm_inc     = frm_q + 1'b1;
  // After a run ends (done or abort) the requester after the owner gets priority.
  assign ptr_next    = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    target_d = target_q;
    dly_d    = '0;
    frm_d    = '0;
    grant_d  = '0;
    done_d   = '0;
    tick_d   = 1'b0;
    busy_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          win_d    = pick_idx;
          target_d = pick_frames;
          if (pick_frames != '0) begin
            state_d = RUN;
            grant_d = pick_oh;
            busy_d  = 1'b1;
          end else begin
            // Zero-frame request completes immediately without a grant.
            state_d = DONE;
            done_d  = pick_oh;
          end
        end
      end

      RUN: begin
        if (!req[win_q]) begin
          // Abort: owner dropped its request before completion.
          state_d = IDLE;
          ptr_d   = ptr_next;
        end else if (dly_q == CNT_W'(TICK_DIV - 1)) begin
          frm_d  = frm_inc;
          tick_d = 1'b1;
          if (frm_inc == target_q) begin
            state_d = DONE;
            done_d  = grant_q;
          end else begin
            grant_d = grant_q;
            busy_d  = 1'b1;
          end
        end else begin
          dly_d   = dly_q + 1'b1;
          frm_d   = frm_q;
          grant_d = grant_q;
          busy_d  = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
        ptr_d   = ptr_next;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      target_q <= '0;
      dly_q    <= '0;
      frm_q    <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      tick_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      target_q <= target_d;
      dly_q    <= dly_d;
      frm_q    <= frm_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      tick_q   <= tick_d;
      busy_q   <= busy_d;
    end
  end

  assign grant      = grant_q;
  assign done       = done_q;
  assign frame_tick = tick_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_frame_timer_scheduler.sv
module tb_frame_timer_scheduler;

  localparam int NR = 4;
  localparam int TD = 4;
  localparam int FW = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [NR-1:0] req = '0;
  logic [NR*FW-1:0] frames = '0;
  logic [NR-1:0] grant;
  logic [NR-1:0] done;
  logic          frame_tick;
  logic          busy;

  frame_timer_scheduler #(
    .NUM_REQ  (NR),
    .TICK_DIV (TD),
    .CNT_W    (20),
    .FRM_W    (FW)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req        (req),
    .frames     (frames),
    .grant      (grant),
    .done       (done),
    .frame_tick (frame_tick),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NR-1:0] g;
    logic [NR-1:0] d;
    logic          t;
    logic          b;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   step  = 0;

  task automatic push(input logic [NR-1:0] g, input logic [NR-1:0] d,
                      input logic t, input logic b);
    exp_t e;
    e.g = g; e.d = d; e.t = t; e.b = b;
    exp_q.push_back(e);
  endtask

  task automatic push_idle(input int n);
    repeat (n) push('0, '0, 1'b0, 1'b0);
  endtask

  // Expected outputs of a run of n frames for requester w, cycles first..last
  // counted from the cycle after the winning IDLE cycle (last=0: to the end).
  // Grant cycles 1..n*TD, k-th tick at 1+k*TD, done at 1+n*TD.
  task automatic push_run(input int w, input int n, input int first, input int last);
    logic [NR-1:0] oh;
    int            stop;
    oh   = NR'(1 << w);
    stop = (last > 0) ? last : n*TD + 1;
    for (int c = first; c <= stop; c++) begin
      if (c == n*TD + 1)
        push('0, oh, (n > 0), 1'b0);
      else
        push(oh, '0, (c > 1) && ((c - 1) % TD == 0), 1'b1);
    end
  endtask

  task automatic drain(input string tag);
    exp_t e, o;
    while (exp_q.size() > 0) begin
      @(posedge clk);
      @(negedge clk);
      step++;
      e = exp_q.pop_front();
      o = {grant, done, frame_tick, busy};
      tests++;
      assert (o === e) else begin
        fails++;
        $error("FAIL %s step%0d got grant=%b done=%b tick=%b busy=%b want grant=%b done=%b tick=%b busy=%b",
               tag, step, o.g, o.d, o.t, o.b, e.g, e.d, e.t, e.b);
      end
    end
  endtask

  initial begin
    // Reset held with all requests raised
    resetn = 1'b0; req = 4'b1111; frames = 16'h1111;
    push_idle(3); drain("reset_hold");
    resetn = 1'b1; req = 4'b0000;
    push_idle(10); drain("idle");

    // Round robin 0 -> 1 -> 3, then 0 again after wrap
    frames = 16'h1111; req = 4'b1011;
    push_run(0, 1, 1, 0); drain("rr_0");
    req = 4'b1010;
    push_idle(1); push_run(1, 1, 1, 0); drain("rr_1");
    req = 4'b1000;
    push_idle(1); push_run(3, 1, 1, 0); drain("rr_3");
    req = 4'b1001;
    push_idle(1); push_run(0, 1, 1, 0); drain("rr_wrap0");
    req = 4'b0000;
    push_idle(1); drain("rr_idle");

    // Single run of 2 frames; frames change mid-run must be ignored
    frames = 16'h0002; req = 4'b0001;
    push_run(0, 2, 1, 3); drain("single_a");
    frames = 16'h0005;
    push_run(0, 2, 4, 0); drain("single_b");
    req = 4'b0000;
    push_idle(1); drain("single_idle");

    // Abort requester 2 after cycle 6
    frames = 16'h0300; req = 4'b0100;
    push_run(2, 3, 1, 6); drain("abort_run");
    req = 4'b0000;
    push_idle(3); drain("abort_after");

    // Delay counter restarts from zero for the next run
    frames = 16'h0001; req = 4'b0001;
    push_run(0, 1, 1, 0); drain("restart");
    req = 4'b0000;
    push_idle(1); drain("restart_idle");

    // Zero-frame request completes with no grant or tick
    frames = 16'h0000; req = 4'b0010;
    push_run(1, 0, 1, 0); drain("zero");
    req = 4'b0000;
    push_idle(2); drain("zero_idle");

    // Reset mid-run clears ptr; requester 0 then beats requester 3
    frames = 16'h2000; req = 4'b1000;
    push_run(3, 2, 1, 3); drain("midrst_run");
    resetn = 1'b0; req = 4'b1001; frames = 16'h2001;
    push_idle(1); drain("midrst_reset");
    resetn = 1'b1;
    push_run(0, 1, 1, 0); drain("midrst_rearb");
    req = 4'b0000;
    push_idle(1); drain("midrst_idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
